xor_puf_crp_ctrl: RTL
=====================

# xor_puf_crp_ctrl

Challenge issuer and response collector for the 3-chain XOR arbiter PUF. Drives a 64-bit challenge onto all three arbiter chains and pulses the race launch. After a settle window it samples the single XOR response bit, repeating each challenge and majority-voting the samples. Voted bits are packed into a response word handed to the host over a valid/ready handshake. It sits between the host/UART logic and the PUF fabric.

## Interface

Parameters:
- RESP_N, 32, response bits per batch (1..255)
- REPS, 5, evaluations per challenge; must be odd (1..15)
- SETTLE, 8, cycles between launch and sample (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a batch; accepted only in IDLE
- seed  in  64  initial LFSR/challenge value, captured on start acceptance
- challenge  out  64  challenge to all arbiter chains
- launch  out  1  one-cycle race-launch pulse to the arbiter chains
- puf_resp  in  1  XOR PUF response bit
- resp_data  out  RESP_N  voted response word
- resp_valid  out  1  resp_data is complete
- resp_ready  in  1  host accepts resp_data
- busy  out  1  high in every state except IDLE
- unstable_cnt  out  8  number of bits in the batch whose REPS samples disagreed

## Operation

- Reset values: challenge=0, launch=0, resp_data=0, resp_valid=0, busy=0, unstable_cnt=0, state=IDLE. A reset in any state returns to IDLE on the next edge and discards the partial batch.
- States: IDLE, LAUNCH, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - challenge <= seed, or 64'h1 if seed==0.
  - resp_data, unstable_cnt, bit and rep counters, and ones counter cleared.
  - Go to LAUNCH.
- LAUNCH: launch=1 for exactly this cycle; challenge held. Go to SETTLE.
- SETTLE: stays exactly SETTLE cycles (down-counter), then goes to SAMPLE.
- SAMPLE (1 cycle): ones += puf_resp.
  - If rep < REPS-1: rep++ and go to LAUNCH with the same challenge.
  - Otherwise, form the voted bit, counting the current sample: vote = (ones_total > REPS/2).
  - resp_data <= {resp_data[RESP_N-2:0], vote}, so the first bit ends at the MSB.
  - unstable_cnt++ if ones_total is neither 0 nor REPS (saturates at 255).
  - Advance the LFSR once; clear rep and ones.
  - If this was bit RESP_N-1, go to DONE; otherwise go to LAUNCH.
- LFSR: Fibonacci, x^64+x^63+x^61+x^60+1. Next = {challenge[62:0], challenge[63]^challenge[62]^challenge[60]^challenge[59]}. It never advances between repetitions of one challenge.
- DONE: resp_valid=1; resp_data and unstable_cnt are frozen. On resp_valid & resp_ready, resp_valid drops and the block goes to IDLE.
- start is ignored while busy, including DONE. resp_data keeps its value in IDLE until the next accepted start.
- challenge changes only on start acceptance and in the final SAMPLE of a bit. It is stable for the whole launch-to-sample window.

## Timing

- Per repetition: 1 (LAUNCH) + SETTLE + 1 (SAMPLE) = SETTLE+2 cycles.
- Per bit: REPS*(SETTLE+2) cycles.
- Latency: if start is accepted at edge k, launch is high in cycle k+1. resp_valid rises at edge k+RESP_N*REPS*(SETTLE+2).
- launch pulses per batch: RESP_N*REPS, each exactly one cycle wide, never back-to-back.
- busy rises at edge k and falls on the handshake edge.
- puf_resp is sampled only in SAMPLE and may change freely elsewhere.
- All outputs are registered.

## Test plan

- **All-ones, nominal timing.** Defaults, seed=64'h1, puf_resp tied 1, resp_ready=1, start pulse. Required: resp_data=32'hFFFFFFFF, unstable_cnt=0, resp_valid 1600 cycles after start, 160 launch pulses.
- **Bare majority.** puf_resp driven 1 on 3 of the 5 SAMPLE cycles of every bit. Required: resp_data=32'hFFFFFFFF, unstable_cnt=32.
  - Repeat with 2 of 5 samples at 1. Required: resp_data=0, unstable_cnt=32.
- **Challenge sequence.** seed=0. Required: first challenge=64'h1, constant across all 5 launches of a bit. The second challenge is 64'h2, and the sequence matches a software model of the LFSR for all 32 bits.
- **Pattern packing.** Model puf_resp = challenge[0] (stable per challenge), seed=64'hA5A5_0000_0000_0001. Required: resp_data equals the model's 32 voted bits, MSB first, with unstable_cnt=0.
- **Backpressure.** resp_ready held 0 for 20 cycles after resp_valid, with start pulsed during DONE. Required: resp_valid stays 1, resp_data stable, start ignored. When resp_ready=1, resp_valid falls on that edge, busy=0, and the next start is accepted.
- **Reset mid-operation.** rst asserted for 1 cycle during SETTLE of bit 10. Required: all outputs return to their reset values on the next edge. A new start with seed=64'h1 yields an exact-timing batch as in the first scenario.

Source files
------------

// File: rtl/xor_puf_crp_ctrl.sv
// Challenge issuer / response collector for a 3-chain XOR arbiter PUF.
// Each LFSR challenge is raced REPS times, the samples are majority-voted and packed MSB-first.
module xor_puf_crp_ctrl #(
  parameter int RESP_N = 32,
  parameter int REPS   = 5,
  parameter int SETTLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       seed,
  output logic [63:0]       challenge,
  output logic              launch,
  input  logic              puf_resp,
  output logic [RESP_N-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy,
  output logic [7:0]        unstable_cnt
);

  // Handshake: resp_data is transferred on a clock edge where resp_valid && resp_ready;
  // resp_valid stays high and resp_data stays frozen until that edge.

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] REPS_L    = 4'(REPS);
  localparam logic [3:0] REPS_LAST = 4'(REPS - 1);
  localparam logic [3:0] REPS_HALF = 4'(REPS / 2);
  localparam logic [7:0] BIT_LAST  = 8'(RESP_N - 1);
  localparam logic [7:0] WAIT_INIT = 8'(SETTLE - 1);

  state_t              state_q, state_d;
  logic [63:0]         challenge_q, challenge_d;
  logic                launch_q, launch_d;
  logic [RESP_N-1:0]   resp_data_q, resp_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                busy_q, busy_d;
  logic [7:0]          unstable_q, unstable_d;
  logic [3:0]          rep_q, rep_d;
  logic [3:0]          ones_q, ones_d;
  logic [7:0]          bit_q, bit_d;
  logic [7:0]          wait_q, wait_d;

  logic [3:0]          ones_total;
  logic                vote;
  logic [63:0]         lfsr_next;

  assign ones_total = ones_q + {3'b000, puf_resp};
  assign vote       = (ones_total > REPS_HALF);
  assign lfsr_next  = {challenge_q[62:0],
                       challenge_q[63] ^ challenge_q[62] ^ challenge_q[60] ^ challenge_q[59]};

  always_comb begin
    state_d      = state_q;
    challenge_d  = challenge_q;
    launch_d     = 1'b0;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    busy_d       = busy_q;
    unstable_d   = unstable_q;
    rep_d        = rep_q;
    ones_d       = ones_q;
    bit_d        = bit_q;
    wait_d       = wait_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
          challenge_d = (seed == 64'h0) ? 64'h1 : seed;
          resp_data_d = '0;
          unstable_d  = 8'h00;
          rep_d       = 4'h0;
          ones_d      = 4'h0;
          bit_d       = 8'h00;
          busy_d      = 1'b1;
          launch_d    = 1'b1;
          state_d     = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        wait_d  = WAIT_INIT;
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (wait_q == 8'h00) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q - 8'h01;
        end
      end

      S_SAMPLE: begin
        if (rep_q != REPS_LAST) begin
          rep_d    = rep_q + 4'h1;
          ones_d   = ones_total;
          launch_d = 1'b1;
          state_d  = S_LAUNCH;
        end else begin
          resp_data_d = (resp_data_q << 1) | RESP_N'(vote);
          if ((ones_total != 4'h0) && (ones_total != REPS_L) && (unstable_q != 8'hFF)) begin
            unstable_d = unstable_q + 8'h01;
          end
          challenge_d = lfsr_next;
          rep_d       = 4'h0;
          ones_d      = 4'h0;
          if (bit_q == BIT_LAST) begin
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            bit_d    = bit_q + 8'h01;
            launch_d = 1'b1;
            state_d  = S_LAUNCH;
          end
        end
      end

      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      challenge_q  <= 64'h0;
      launch_q     <= 1'b0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      unstable_q   <= 8'h00;
      rep_q        <= 4'h0;
      ones_q       <= 4'h0;
      bit_q        <= 8'h00;
      wait_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      challenge_q  <= challenge_d;
      launch_q     <= launch_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      unstable_q   <= unstable_d;
      rep_q        <= rep_d;
      ones_q       <= ones_d;
      bit_q        <= bit_d;
      wait_q       <= wait_d;
    end
  end

  assign challenge    = challenge_q;
  assign launch       = launch_q;
  assign resp_data    = resp_data_q;
  assign resp_valid   = resp_valid_q;
  assign busy         = busy_q;
  assign unstable_cnt = unstable_q;

endmodule
